// File: rtl/mult_accum.sv
// mult_accum: signed dot-product accumulator placed behind the 4-stage
// pipelined 16-bit multiplier. Each group of LEN products is summed into an
// ACC_W-bit result. Results are queued in a first-word-fall-through FIFO with
// a valid/ready output. A slot-reservation counter tells the issuer whether a
// new vector's result is guaranteed a FIFO entry.
// Build option: define MULT_ACCUM_SAT_EN to clamp on overflow; the default
// build wraps in two's complement. ovf is raised in both builds.
module mult_accum #(
    parameter int LEN       = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    input  logic             vec_start,
    output logic             vec_credit,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             err
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);

`ifdef MULT_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic {IDLE, ACC} state_t;

    // One accumulation step: the value to store and whether it overflowed.
    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] sum;
    } step_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [ACC_W-1:0]                 acc_q, acc_d;
    logic [ACC_W-1:0]                 p_ext, addend, raw_sum;
    step_t                            step;
    logic                             is_last, push;

    logic [OUT_DEPTH-1:0][ACC_W-1:0]  mem;
    logic [PTR_W-1:0]                 rd_ptr, wr_ptr;
    logic [OCC_W-1:0]                 occ_q, occ_d;
    logic [OCC_W-1:0]                 slots_q, slots_d;
    logic [ACC_W-1:0]                 last_q;
    logic                             ovf_q, err_q;
    logic                             pop, full, push_ok, push_drop;
    logic                             start_ok, start_bad;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Datapath: sign-extend the product and add it to the running sum (or to
    // zero when starting a fresh vector); flag same-sign addends whose sum
    // flips sign.
    always_comb begin
        p_ext    = {{(ACC_W-16){prod_in[15]}}, prod_in};
        addend   = (state_q == ACC) ? acc_q : '0;
        raw_sum  = addend + p_ext;
        step.ovf = (addend[ACC_W-1] == p_ext[ACC_W-1]) &&
                   (raw_sum[ACC_W-1] != p_ext[ACC_W-1]);
`ifdef MULT_ACCUM_SAT_EN
        if (step.ovf) step.sum = p_ext[ACC_W-1] ? SAT_MIN : SAT_MAX;
        else          step.sum = raw_sum;
`else
        step.sum = raw_sum;
`endif
        is_last  = (cnt_q == CNT_W'(LEN - 1));
    end

    // Next-state logic: count products, emit a push on the last one of a vector.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (prod_valid) begin
            acc_d = step.sum;
            if (is_last) begin
                cnt_d   = '0;
                state_d = IDLE;
                push    = 1'b1;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ACC;
            end
        end
    end

    // Accumulator state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake qualification. A start is judged against the slot count held
    // in the register, so a same-cycle pop does not rescue it. A push into a
    // full FIFO survives only when the head leaves on the same edge.
    always_comb begin
        acc_valid  = (occ_q != '0);
        vec_credit = (slots_q < OCC_W'(OUT_DEPTH));
        pop        = acc_valid && acc_ready;
        full       = (occ_q == OCC_W'(OUT_DEPTH));
        push_ok    = push && (!full || pop);
        push_drop  = push && full && !pop;
        start_ok   = vec_start && vec_credit;
        start_bad  = vec_start && !vec_credit;
        acc_out    = acc_valid ? mem[rd_ptr] : last_q;
    end

    // Occupancy and reservation counters; a pop with no outstanding
    // reservation leaves the slot count at zero.
    always_comb begin
        occ_d = occ_q;
        if (push_ok && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!push_ok && pop) occ_d = occ_q - OCC_W'(1);
        slots_d = slots_q;
        if (start_ok && !(pop && slots_q != '0))      slots_d = slots_q + OCC_W'(1);
        else if (!start_ok && pop && slots_q != '0)   slots_d = slots_q - OCC_W'(1);
    end

    // FIFO storage; contents are only meaningful below the occupancy count,
    // so the array itself needs no reset.
    always_ff @(posedge clock) begin
        if (reset && push_ok) mem[wr_ptr] <= step.sum;
    end

    // FIFO pointers, counters, output hold register and sticky flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ_q   <= '0;
            slots_q <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            occ_q   <= occ_d;
            slots_q <= slots_d;
            last_q  <= acc_out;
            ovf_q   <= ovf_q | (prod_valid && step.ovf);
            err_q   <= err_q | start_bad | push_drop;
        end
    end

    assign ovf = ovf_q;
    assign err = err_q;

    // Structural invariants of the counters and the output handshake.
    a_occ_range: assert property (@(posedge clock) disable iff (!reset)
        occ_q <= OCC_W'(OUT_DEPTH));
    a_slot_range: assert property (@(posedge clock) disable iff (!reset)
        slots_q <= OCC_W'(OUT_DEPTH));
    a_idle_cnt: assert property (@(posedge clock) disable iff (!reset)
        (state_q == IDLE) == (cnt_q == '0));
    a_hold: assert property (@(posedge clock) disable iff (!reset)
        (acc_valid && !acc_ready) |=> (acc_valid && $stable(acc_out)));

endmodule

// File: tb/tb_mult_accum.sv
// Scoreboard bench for mult_accum: a reference model pushes expected results
// on every clock edge, and a monitor on the falling edge compares the DUT's
// outputs and pops accepted results. A second instance (LEN=5, ACC_W=18)
// covers the overflow/saturation corner.
module tb_mult_accum;
    localparam int LEN = 4, ACC_W = 32, DEPTH = 4;
    localparam int S_LEN = 5, S_W = 18;

    logic clock = 1'b0, reset = 1'b0;
    logic [15:0] prod_in = '0;
    logic prod_valid = 1'b0, vec_start = 1'b0, acc_ready = 1'b0;
    logic vec_credit, acc_valid, ovf, err;
    logic [ACC_W-1:0] acc_out;

    logic [15:0] s_prod = '0;
    logic s_pv = 1'b0, s_vs = 1'b0, s_rdy = 1'b0;
    logic s_credit, s_valid, s_ovf, s_err;
    logic [S_W-1:0] s_out;

    int passed = 0, total = 0;

    always #5 clock = ~clock;

    mult_accum #(.LEN(LEN), .ACC_W(ACC_W), .OUT_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
        .vec_start(vec_start), .vec_credit(vec_credit), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf), .err(err));

    mult_accum #(.LEN(S_LEN), .ACC_W(S_W), .OUT_DEPTH(2)) dut_s (
        .clock(clock), .reset(reset), .prod_in(s_prod), .prod_valid(s_pv),
        .vec_start(s_vs), .vec_credit(s_credit), .acc_out(s_out),
        .acc_valid(s_valid), .acc_ready(s_rdy), .ovf(s_ovf), .err(s_err));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else passed++;
    endtask

    // Adds p to a signed w-bit running sum using plain integer arithmetic;
    // o reports that the exact sum left the representable range.
    function automatic longint fold(input longint a, input longint p, input int w, output bit o);
        longint mx, mn, s;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s  = a + p;
        o  = (s > mx) || (s < mn);
`ifdef MULT_ACCUM_SAT_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`else
        if (s > mx) s = s - (longint'(1) <<< w);
        else if (s < mn) s = s + (longint'(1) <<< w);
`endif
        return s;
    endfunction

    // Reference model state, advanced once per rising edge.
    int mcnt = 0, mslots = 0, mocc = 0;
    longint macc = 0;
    bit movf = 0, merr = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] mlast = '0;

    initial forever begin
        bit pop_m, dec_m, o;
        longint s;
        @(posedge clock);
        if (!reset) begin
            mcnt = 0; mslots = 0; mocc = 0; macc = 0; movf = 0; merr = 0;
        end else begin
            pop_m = (mocc > 0) && acc_ready;
            dec_m = pop_m && (mslots > 0);
            if (vec_start) begin
                if (mslots < DEPTH) mslots = mslots + 1;
                else merr = 1;
            end
            if (dec_m) mslots = mslots - 1;
            if (prod_valid) begin
                s = fold((mcnt == 0) ? 0 : macc, longint'($signed(prod_in)), ACC_W, o);
                if (o) movf = 1;
                macc = s;
                mcnt = mcnt + 1;
                if (mcnt == LEN) begin
                    mcnt = 0;
                    if (mocc < DEPTH || pop_m) begin
                        exp_q.push_back(s[ACC_W-1:0]);
                        mocc = mocc + 1;
                    end else merr = 1;
                end
            end
            if (pop_m) mocc = mocc - 1;
        end
    end

    // Monitor: compares the visible state against the model between edges.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            mlast = '0;
            exp_q.delete();
        end else begin
            check("acc_valid", acc_valid, mocc > 0);
            check("vec_credit", vec_credit, mslots < DEPTH);
            check("err", err, merr);
            check("ovf", ovf, movf);
            if (acc_valid) begin
                if (exp_q.size() == 0) check("unexpected_result", acc_out, 64'hDEAD_0000);
                else begin
                    check("acc_out", acc_out, exp_q[0]);
                    if (acc_ready) mlast = exp_q.pop_front();
                end
            end else check("acc_out_hold", acc_out, mlast);
        end
    end

    task automatic cyc(input bit pv, input logic [15:0] p, input bit vs, input bit rdy);
        prod_valid = pv; prod_in = p; vec_start = vs; acc_ready = rdy;
        @(posedge clock); #1;
    endtask

    task automatic vec4(input logic [15:0] a, b, c, d, input bit vs, input bit rdy);
        cyc(1, a, vs, rdy); cyc(1, b, 0, rdy); cyc(1, c, 0, rdy); cyc(1, d, 0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b0; cyc(0, 0, 0, 0); reset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"}, acc_out, 0);
        check({tag, "_valid"}, acc_valid, 0);
        check({tag, "_credit"}, vec_credit, 1);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        longint sexp;
        bit so, sov;
        logic [S_W-1:0] s_exp;

        reset = 1'b0; cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); reset = 1'b1;
        check_reset_state("reset");
        check("s_reset_valid", s_valid, 0);

        // Basic sum, result visible right after the 4th product edge.
        vec4(16'd1, 16'd2, 16'd3, 16'd4, 1, 0);
        check("basic_valid", acc_valid, 1);
        check("basic_sum", acc_out, 32'h0000000A);
        cyc(0, 0, 0, 1);
        check("basic_pop_valid", acc_valid, 0);
        check("basic_pop_credit", vec_credit, 1);

        // Signed products, back-to-back vectors.
        vec4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1);
        check("neg_sum", acc_out, 32'hFFFFFFFC);
        vec4(16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 1, 1);
        check("mixed_sum", acc_out, 32'h00000000);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // Fill to the credit limit, then push and pop on the same edge.
        do_reset();
        for (int v = 0; v < DEPTH; v++)
            vec4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 0);
        check("full_credit", vec_credit, 0);
        check("full_valid", acc_valid, 1);
        cyc(1, 16'd10, 0, 0); cyc(1, 16'd20, 0, 0); cyc(1, 16'd30, 0, 0);
        cyc(1, 16'd40, 0, 1);
        check("pushpop_err", err, 0);
        check("pushpop_valid", acc_valid, 1);
        cyc(0, 0, 1, 0);
        check("relimit_credit", vec_credit, 0);
        cyc(0, 0, 1, 1);
        check("start_pop_err", err, 1);
        check("start_pop_credit", vec_credit, 1);
        for (int i = 0; i < 20 && acc_valid; i++) cyc(0, 0, 0, 1);
        check("drain1_valid", acc_valid, 0);

        // Reset in the middle of a vector discards the partial sum.
        cyc(1, 16'd7, 1, 0); cyc(1, 16'd9, 0, 0);
        do_reset();
        check_reset_state("midreset");
        vec4(16'd5, 16'd5, 16'd5, 16'd5, 1, 0);
        check("after_reset_sum", acc_out, 32'h00000014);
        cyc(0, 0, 0, 1);

        // Overflow on the narrow instance: expected value from plain arithmetic.
        sexp = 0; sov = 0;
        for (int i = 0; i < S_LEN; i++) begin
            sexp = fold(sexp, 32767, S_W, so);
            if (so) sov = 1;
        end
        s_exp = sexp[S_W-1:0];
        s_pv = 1'b1; s_prod = 16'h7FFF;
        for (int i = 0; i < S_LEN; i++) cyc(0, 0, 0, 0);
        s_pv = 1'b0;
        check("sat_valid", s_valid, 1);
        check("sat_value", s_out, s_exp);
        check("sat_ovf", s_ovf, sov);

        // Randomized traffic, including credit misuse and back-pressure.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) != 0);

        for (int i = 0; i < 60 && mocc != 0; i++) cyc(0, 0, 0, 1);
        check("drain_done", mocc, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
